// File: rtl/solo_squash_pkg.sv
// Shared types and constants for the solo_squash power-up sequencer.
package solo_squash_pkg;

   typedef enum logic {
      WAIT_READY = 1'b0,
      RUN        = 1'b1
   } ssq_state_t;

   // Pad output-enable bars: all drivers off / all drivers on.
   localparam logic [5:0] SSQ_OEB_OFF = 6'h3F;
   localparam logic [5:0] SSQ_OEB_ON  = 6'h00;

   // Slot of each button in the conditioned key vector.
   localparam int KEY_PAUSE    = 0;
   localparam int KEY_NEW_GAME = 1;
   localparam int KEY_UP       = 2;
   localparam int KEY_DOWN     = 3;
   localparam int NUM_KEYS     = 4;

endpackage

// File: rtl/ssq_debounce.sv
// One button: 2-flop synchroniser followed by an optional hold-off counter.
// Build macro SSQ_DEBOUNCE_EN enables the counter; without it the held
// level is simply the synchronised pin.
module ssq_debounce
   import solo_squash_pkg::*;
#(
   parameter int DEBOUNCE_BITS = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic stable
);

   logic [1:0] sync;

   // Bring the raw active-low pin into the clock domain; idle level is 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= 2'b11;
      else        sync <= {sync[0], pin};
   end

`ifdef SSQ_DEBOUNCE_EN
   logic [DEBOUNCE_BITS-1:0] cnt;
   logic                     held;

   // Accept a new level only after it has disagreed with the held level for
   // a full counter wrap; any agreeing cycle restarts the wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held <= 1'b1;
         cnt  <= '0;
      end else if (sync[1] == held) begin
         cnt  <= '0;
      end else if (&cnt) begin
         held <= sync[1];
         cnt  <= '0;
      end else begin
         cnt  <= cnt + 1'b1;
      end
   end

   assign stable = held;
`else
   // Keeps the width parameter referenced when the counter is compiled out.
   localparam int unused_debounce_bits = DEBOUNCE_BITS;

   assign stable = sync[1];
`endif

endmodule

// File: rtl/solo_squash_ctrl.sv
// Power-up sequencer and button conditioner for the solo_squash core.
// Holds the core in reset with pads tri-stated until gpio_ready has been
// stable for READY_HOLD cycles. Build macro SSQ_DEBOUNCE_EN selects
// debounced keys (see ssq_debounce).
module solo_squash_ctrl
   import solo_squash_pkg::*;
#(
   parameter int DEBOUNCE_BITS = 16,
   parameter int READY_HOLD    = 256
) (
   input  logic       wb_clk_i,
   input  logic       sys_reset_n,
   input  logic       gpio_ready,
   input  logic       pause_n,
   input  logic       new_game_n,
   input  logic       up_key_n,
   input  logic       down_key_n,
   output logic       design_reset,
   output logic       pause,
   output logic       up_key,
   output logic       down_key,
   output logic       new_game,
   output logic       debug_design_reset,
   output logic       debug_gpio_ready,
   output logic [5:0] design_oeb,
   output logic [1:0] debug_oeb
);

   localparam int             CW      = $clog2(READY_HOLD + 1);
   localparam logic [CW-1:0]  HOLD    = CW'(READY_HOLD);
   localparam logic [CW-1:0]  HOLD_M1 = CW'(READY_HOLD - 1);

   logic [1:0]          rdy_sync;
   logic                ready;
   logic [NUM_KEYS-1:0] pins;
   logic [NUM_KEYS-1:0] stable;
   logic [CW-1:0]       cnt;
   ssq_state_t          state, next;
   logic                ng_prev;
   logic [1:0]          dbg_oeb_q;

   // gpio_ready comes from the management SoC asynchronously; idle low.
   always_ff @(posedge wb_clk_i or negedge sys_reset_n) begin
      if (!sys_reset_n) rdy_sync <= 2'b00;
      else              rdy_sync <= {rdy_sync[0], gpio_ready};
   end
   assign ready = rdy_sync[1];

   assign pins[KEY_PAUSE]    = pause_n;
   assign pins[KEY_NEW_GAME] = new_game_n;
   assign pins[KEY_UP]       = up_key_n;
   assign pins[KEY_DOWN]     = down_key_n;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      ssq_debounce #(
         .DEBOUNCE_BITS (DEBOUNCE_BITS)
      ) u_db (
         .clk    (wb_clk_i),
         .rst_n  (sys_reset_n),
         .pin    (pins[k]),
         .stable (stable[k])
      );
   end

   // Count consecutive ready cycles; any low cycle restarts, saturate at HOLD.
   always_ff @(posedge wb_clk_i or negedge sys_reset_n) begin
      if (!sys_reset_n)    cnt <= '0;
      else if (!ready)     cnt <= '0;
      else if (cnt != HOLD) cnt <= cnt + 1'b1;
   end

   // State register.
   always_ff @(posedge wb_clk_i or negedge sys_reset_n) begin
      if (!sys_reset_n) state <= WAIT_READY;
      else              state <= next;
   end

   // Release on the edge the counter reaches HOLD; fall back on any ready drop.
   always_comb begin
      next         = state;
      design_reset = 1'b1;
      design_oeb   = SSQ_OEB_OFF;
      case (state)
         WAIT_READY: begin
            if (ready && cnt >= HOLD_M1) next = RUN;
         end
         RUN: begin
            design_reset = 1'b0;
            design_oeb   = SSQ_OEB_ON;
            if (!ready) next = WAIT_READY;
         end
         default: next = WAIT_READY;
      endcase
   end

   // Previous held new-game level for falling-edge detection.
   always_ff @(posedge wb_clk_i or negedge sys_reset_n) begin
      if (!sys_reset_n) ng_prev <= 1'b1;
      else              ng_prev <= stable[KEY_NEW_GAME];
   end

   // Debug pads stay tri-stated only while the system reset is asserted.
   always_ff @(posedge wb_clk_i or negedge sys_reset_n) begin
      if (!sys_reset_n) dbg_oeb_q <= 2'b11;
      else              dbg_oeb_q <= 2'b00;
   end

   // A press is only honoured in RUN, so a same-edge ready drop suppresses it.
   assign new_game = (state == RUN) && ng_prev && !stable[KEY_NEW_GAME];

   assign pause              = ~stable[KEY_PAUSE];
   assign up_key             = ~stable[KEY_UP];
   assign down_key           = ~stable[KEY_DOWN];
   assign debug_design_reset = design_reset;
   assign debug_gpio_ready   = ready;
   assign debug_oeb          = dbg_oeb_q;

endmodule

// File: tb/tb_solo_squash_ctrl.sv
// Bench for solo_squash_ctrl: expected output vectors are queued against an
// absolute edge number as stimulus is driven and compared on the falling edge.
module tb_solo_squash_ctrl;

   localparam int DB = 4;
   localparam int RH = 8;
`ifdef SSQ_DEBOUNCE_EN
   localparam int LAT = 2 + (1 << DB);
   localparam bit DEB = 1'b1;
`else
   localparam int LAT = 2;
   localparam bit DEB = 1'b0;
`endif

   typedef struct packed {
      logic       dr;
      logic       ddr;
      logic [5:0] oeb;
      logic [1:0] doeb;
      logic       pause;
      logic       up;
      logic       down;
      logic       ng;
      logic       gr;
   } out_t;

   typedef struct {
      int    cyc;
      string name;
      out_t  exp;
   } sb_t;

   typedef struct {
      logic [3:0] kn;   // {pause_n, new_game_n, up_key_n, down_key_n}
      bit p, u, d, ng;
   } vec_t;

   logic clk = 1'b0;
   logic sys_reset_n, gpio_ready, pause_n, new_game_n, up_key_n, down_key_n;
   logic design_reset, pause, up_key, down_key, new_game;
   logic debug_design_reset, debug_gpio_ready;
   logic [5:0] design_oeb;
   logic [1:0] debug_oeb;

   out_t obs;
   sb_t  sbq[$];
   int   cyc   = 0;
   int   nchk  = 0;
   int   npass = 0;
   bit   done  = 1'b0;

   solo_squash_ctrl #(
      .DEBOUNCE_BITS (DB),
      .READY_HOLD    (RH)
   ) dut (
      .wb_clk_i           (clk),
      .sys_reset_n        (sys_reset_n),
      .gpio_ready         (gpio_ready),
      .pause_n            (pause_n),
      .new_game_n         (new_game_n),
      .up_key_n           (up_key_n),
      .down_key_n         (down_key_n),
      .design_reset       (design_reset),
      .pause              (pause),
      .up_key             (up_key),
      .down_key           (down_key),
      .new_game           (new_game),
      .debug_design_reset (debug_design_reset),
      .debug_gpio_ready   (debug_gpio_ready),
      .design_oeb         (design_oeb),
      .debug_oeb          (debug_oeb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign obs = {design_reset, debug_design_reset, design_oeb, debug_oeb,
                 pause, up_key, down_key, new_game, debug_gpio_ready};

   function automatic out_t ev(input bit run, input bit gr, input bit p,
                               input bit u, input bit d, input bit ng);
      out_t o;
      o.dr    = !run;
      o.ddr   = !run;
      o.oeb   = run ? 6'h00 : 6'h3F;
      o.doeb  = 2'b00;
      o.pause = p;
      o.up    = u;
      o.down  = d;
      o.ng    = ng;
      o.gr    = gr;
      return o;
   endfunction

   function automatic out_t rv();
      out_t o;
      o      = '0;
      o.dr   = 1'b1;
      o.ddr  = 1'b1;
      o.oeb  = 6'h3F;
      o.doeb = 2'b11;
      return o;
   endfunction

   function automatic string fmt(input out_t o);
      return $sformatf("dr=%b ddr=%b oeb=%h doeb=%b p/u/d=%b%b%b ng=%b gr=%b",
                       o.dr, o.ddr, o.oeb, o.doeb, o.pause, o.up, o.down, o.ng, o.gr);
   endfunction

   task automatic expect_at(input int c, input string n, input out_t e);
      sbq.push_back('{c, n, e});
   endtask

   task automatic step_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Scoreboard: compare every entry due on this edge; stale or never-reached
   // entries count as failures.
   always @(negedge clk) begin
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (done || sbq[i].cyc <= cyc) begin
            nchk = nchk + 1;
            if (!done && sbq[i].cyc == cyc && obs === sbq[i].exp)
               npass = npass + 1;
            else
               $display("FAIL %s @edge %0d (due %0d): got %s want %s",
                        sbq[i].name, cyc, sbq[i].cyc, fmt(obs), fmt(sbq[i].exp));
            sbq.delete(i);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t tbl[6];
      vec_t prv;
      int t, m, g, n, s, x, r, a, q, q2;
      int offs[6];

      tbl[0] = '{4'b1111, 0, 0, 0, 0};
      tbl[1] = '{4'b0111, 1, 0, 0, 0};
      tbl[2] = '{4'b0010, 1, 0, 1, 1};
      tbl[3] = '{4'b1100, 0, 1, 1, 0};
      tbl[4] = '{4'b1011, 0, 0, 0, 1};
      tbl[5] = '{4'b1111, 0, 0, 0, 0};

      sys_reset_n = 1'b0;
      gpio_ready  = 1'b0;
      pause_n     = 1'b1;
      new_game_n  = 1'b1;
      up_key_n    = 1'b1;
      down_key_n  = 1'b1;

      // Reset state.
      @(posedge clk);
      #2;
      nchk = nchk + 1;
      if (debug_oeb === 2'b11 && design_oeb === 6'h3F) npass = npass + 1;
      else $display("FAIL direct_reset_oeb: doeb=%b oeb=%h", debug_oeb, design_oeb);
      expect_at(cyc,     "reset",      rv());
      expect_at(cyc + 1, "reset_hold", rv());
      step_to(3);

      // Release with gpio_ready already high: run on edge 2+RH.
      t = cyc;
      sys_reset_n = 1'b1;
      gpio_ready  = 1'b1;
      expect_at(t + 1,      "dbg_oeb_rel", ev(0, 0, 0, 0, 0, 0));
      expect_at(t + 2,      "ready_sync",  ev(0, 1, 0, 0, 0, 0));
      expect_at(t + RH + 1, "ready_hold",  ev(0, 1, 0, 0, 0, 0));
      expect_at(t + RH + 2, "release",     ev(1, 1, 0, 0, 0, 0));
      step_to(t + RH + 4);
      nchk = nchk + 1;
      if (design_reset === 1'b0 && design_oeb === 6'h00) npass = npass + 1;
      else $display("FAIL direct_release: dr=%b oeb=%h", design_reset, design_oeb);
      nchk = nchk + 1;
      if (debug_oeb === 2'b00 && debug_gpio_ready === 1'b1) npass = npass + 1;
      else $display("FAIL direct_dbg_run: doeb=%b gr=%b", debug_oeb, debug_gpio_ready);

      // Key table: each row changes some keys together, checked around latency.
      prv = '{4'b1111, 0, 0, 0, 0};
      for (int i = 0; i < 6; i++) begin
         t = cyc;
         {pause_n, new_game_n, up_key_n, down_key_n} = tbl[i].kn;
         expect_at(t + LAT - 1, $sformatf("vec%0d_pre", i),
                   ev(1, 1, prv.p, prv.u, prv.d, 0));
         expect_at(t + LAT, $sformatf("vec%0d", i),
                   ev(1, 1, tbl[i].p, tbl[i].u, tbl[i].d, tbl[i].ng));
         expect_at(t + LAT + 1, $sformatf("vec%0d_post", i),
                   ev(1, 1, tbl[i].p, tbl[i].u, tbl[i].d, 0));
         step_to(t + LAT + 2);
         prv = tbl[i];
      end

      // up_key_n low 10 cycles (rejected when debounced), then low 20.
      t = cyc;
      up_key_n = 1'b0;
      expect_at(t + 1,  "short_up_e1",  ev(1, 1, 0, 0, 0, 0));
      expect_at(t + 2,  "short_up_e2",  ev(1, 1, 0, !DEB, 0, 0));
      expect_at(t + 11, "short_up_e11", ev(1, 1, 0, !DEB, 0, 0));
      expect_at(t + 12, "short_up_e12", ev(1, 1, 0, 0, 0, 0));
      step_to(t + 10);
      up_key_n = 1'b1;
      step_to(t + 20);
      m = cyc;
      up_key_n = 1'b0;
      expect_at(m + LAT - 1, "long_up_pre",  ev(1, 1, 0, 0, 0, 0));
      expect_at(m + LAT,     "long_up_rise", ev(1, 1, 0, 1, 0, 0));
      step_to(m + 20);
      up_key_n = 1'b1;
      expect_at(m + 20 + LAT - 1, "up_rel_pre",  ev(1, 1, 0, 1, 0, 0));
      expect_at(m + 20 + LAT,     "up_rel_fall", ev(1, 1, 0, 0, 0, 0));
      step_to(m + 20 + LAT + 2);

      // One-cycle glitch on pause_n: passes straight through without debounce.
      g = cyc;
      pause_n = 1'b0;
      step_to(g + 1);
      pause_n = 1'b1;
      expect_at(g + 2,  "pause_glitch",      ev(1, 1, !DEB, 0, 0, 0));
      expect_at(g + 3,  "pause_glitch_end",  ev(1, 1, 0, 0, 0, 0));
      expect_at(g + 20, "pause_glitch_late", ev(1, 1, 0, 0, 0, 0));
      step_to(g + 22);

      // new_game_n held low 40 cycles: one pulse, none on release.
      n = cyc;
      new_game_n = 1'b0;
      for (int k = 1; k <= 40 + LAT + 2; k++)
         expect_at(n + k, $sformatf("ng_hold_e%0d", k), ev(1, 1, 0, 0, 0, k == LAT));
      step_to(n + 40);
      new_game_n = 1'b1;
      step_to(n + 40 + LAT + 3);

      // Ready drop and a new-game press landing on the same edge x.
      s = cyc;
      x = s + 20;
      expect_at(x - 2, "drop_pre2", ev(1, 1, 0, 0, 0, 0));
      expect_at(x - 1, "drop_sync", ev(1, 0, 0, 0, 0, 0));
      expect_at(x,     "drop_wait", ev(0, 0, 0, 0, 0, 0));
      expect_at(x + 1, "drop_nopls", ev(0, 0, 0, 0, 0, 0));
      for (int c = s + 1; c <= x - 1; c++) begin
         step_to(c);
         if (c == x - LAT) new_game_n = 1'b0;
         if (c == x - 3)   gpio_ready = 1'b0;
      end
      step_to(x + 3);
      new_game_n = 1'b1;
      step_to(x + 3 + LAT + 2);

      // Ready high 5, low 1, high: counter restarts from the final rise.
      r = cyc;
      gpio_ready = 1'b1;
      expect_at(r + 2,  "glitch_sync",  ev(0, 1, 0, 0, 0, 0));
      expect_at(r + 7,  "glitch_low",   ev(0, 0, 0, 0, 0, 0));
      expect_at(r + 8,  "glitch_high",  ev(0, 1, 0, 0, 0, 0));
      expect_at(r + 10, "glitch_norel", ev(0, 1, 0, 0, 0, 0));
      expect_at(r + 15, "glitch_pre",   ev(0, 1, 0, 0, 0, 0));
      expect_at(r + 16, "glitch_rel",   ev(1, 1, 0, 0, 0, 0));
      step_to(r + 5);
      gpio_ready = 1'b0;
      step_to(r + 6);
      gpio_ready = 1'b1;
      step_to(r + 18);

      // Mid-run asynchronous reset with a key held, then re-release.
      a = cyc;
      up_key_n = 1'b0;
      expect_at(a + LAT, "pre_rst_up", ev(1, 1, 0, 1, 0, 0));
      step_to(a + LAT + 1);
      q = cyc;
      sys_reset_n = 1'b0;
      expect_at(q,     "async_rst",      rv());
      expect_at(q + 1, "async_rst_hold", rv());
      step_to(q + 2);
      nchk = nchk + 1;
      if (design_reset === 1'b1 && debug_oeb === 2'b11 && up_key === 1'b0) npass = npass + 1;
      else $display("FAIL direct_async_rst: dr=%b doeb=%b up=%b", design_reset, debug_oeb, up_key);
      q2 = cyc;
      sys_reset_n = 1'b1;
      offs = '{1, LAT - 1, LAT, 9, 10, 11};
      foreach (offs[j])
         expect_at(q2 + offs[j], $sformatf("rerel_e%0d", offs[j]),
                   ev(offs[j] >= 10, offs[j] >= 2, 0, offs[j] >= LAT, 0, 0));
      step_to(q2 + LAT + 12);
      t = cyc;
      up_key_n = 1'b1;
      expect_at(t + LAT, "final_up_rel", ev(1, 1, 0, 0, 0, 0));
      step_to(t + LAT + 2);

      done = 1'b1;
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
